lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Sequential load/store front-end between the NPC memory stage and a data-memory port. Accepts one LSU request at a time over a valid/ready handshake, checks alignment and type legality, and issues one naturally aligned memory beat with byte strobes. Returns sign- or zero-extended load data, or a store acknowledge, with an error code. Supersedes the combinational DPI memory hookup: memory latency, backpressure, bus errors and timeouts are handled explicitly, so the DPI `pmem_read`/`pmem_write` adapter becomes a plain memory-side slave.

## Interface
- `XLEN`, 64: data/address width; 32 or 64 only.
- `TIMEOUT`, 255: max cycles in WAIT before bus-timeout error; 0 disables the timeout.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_addr` in XLEN: byte address.
- `req_type` in 3: RV funct3; 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 illegal.
- `req_wen` in 1: 1 = store.
- `req_wdata` in XLEN: store data, right-justified.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed when `rsp_valid && rsp_ready`.
- `rsp_rdata` out XLEN: extended load data; 0 for stores and errors.
- `rsp_err` out 2: 00 ok, 01 misaligned/illegal, 10 bus error, 11 timeout.
- `mem_req_valid` out 1: memory beat request.
- `mem_req_ready` in 1: memory accepts beat.
- `mem_req_addr` out XLEN: `req_addr` with low log2(XLEN/8) bits cleared.
- `mem_req_wen` out 1: write beat.
- `mem_req_wdata` out XLEN: lane-shifted store data.
- `mem_req_wstrb` out XLEN/8: byte strobes; all 0 on reads.
- `mem_rsp_valid` in 1: one response per accepted beat; always accepted.
- `mem_rsp_rdata` in XLEN: full aligned beat.
- `mem_rsp_err` in 1: bus error.

## Operation
- States: IDLE, MREQ, WAIT, RESP.
- IDLE: `req_ready`=1. On accept, latch all request fields. If illegal -> RESP with err 01, no memory access. Otherwise -> MREQ.
- Illegal means any of:
  - type 111;
  - store with `req_type[2]`=1;
  - XLEN=32 with type 011 or 110;
  - addr not a multiple of the access size.
- MREQ: `mem_req_valid`=1 with stable fields until `mem_req_ready`, then -> WAIT.
  - If the `stale` flag is set, `mem_req_valid` is held 0 until it clears.
- WAIT: on `mem_rsp_valid`, capture and go to RESP.
  - `mem_rsp_err` gives err 10 with rdata 0.
  - Loads: shift beat right by 8*offset, then sign-extend (B/H/W) or zero-extend (BU/HU/WU/D) from the size.
  - Stores: rdata 0.
- Timeout: the WAIT counter starts at 0 on entry. When it reaches `TIMEOUT`-1 without a response, go to RESP with err 11 and set `stale`.
- RESP: `rsp_valid`=1, outputs held stable until `rsp_ready`, then -> IDLE.
- `stale`: while set, the next `mem_rsp_valid` (any state) is discarded and clears `stale`.
  - A response arriving in the same cycle as the timeout is taken as a normal response; `stale` is not set and err is not 11.
- Store lanes: `wdata << 8*offset`; `wstrb = ((1<<size_bytes)-1) << offset`.

## Timing
- Reset values: state IDLE, `stale`=0, counter 0. All outputs 0 except `req_ready`=1 (IDLE). `rsp_rdata`/`rsp_err` 0.
- Asserting reset mid-transaction returns to IDLE immediately and drops the transaction. The memory side is assumed reset together with this block, so `stale` is cleared.
- Best-case latency: accept at cycle 0, `mem_req_valid` at 1 (ready same cycle), `mem_rsp_valid` at 2, `rsp_valid` at 3.
- Illegal request: `rsp_valid` at cycle 1.
- No new request is accepted in the cycle a response handshakes; next accept is earliest the following cycle (IDLE).
- `mem_rsp_valid` outside WAIT with `stale`=0 is a protocol violation; the block ignores it and the assertion fires.

## Structure
- `lsu_pkg`: funct3 type constants, err code constants, state enum, `size_bytes(type)` function.
- Sub-module `lsu_align`: purely combinational. Computes store lane shift/strobe, load extract/extend and the misalign/illegal check. Parametrised by `XLEN`.
- Top: FSM, request latches, timeout counter, stale flag.

## Test plan
- LW at 0x8000_0004, beat 0xDEAD_BEEF_8765_4321 -> `mem_req_addr` 0x8000_0000; rdata 0xFFFF_FFFF_DEAD_BEEF, err 00; `rsp_valid` at cycle 3.
- SH at 0x8000_0006, wdata 0x1234_ABCD -> wdata 0xABCD_0000_0000_0000, wstrb 0xC0, err 00 on ack.
- LBU at 0x...03, beat 0x...80_00_00_00 -> rdata 0x80. LB at the same address -> rdata 0xFFFF_FFFF_FFFF_FF80.
- LD at 0x...04 and type 111 -> err 01 at cycle 1; `mem_req_valid` never asserted.
- `TIMEOUT`=8, memory silent -> err 11 after 8 WAIT cycles. The next request's `mem_req_valid` is held low until the late response arrives; that late response is discarded and the next request completes with correct data.
- `mem_req_ready` low 5 cycles, `rsp_ready` low 3 cycles, `mem_rsp_err`=1 -> request fields stable throughout; err 10, rdata 0; reset mid-WAIT returns `req_ready`=1 immediately.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants for the LSU memory front-end: funct3 access types, response
// error codes, FSM state encodings and the access-size helper.
package lsu_pkg;

    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_WU  = 3'b110;
    localparam logic [2:0] F3_ILL = 3'b111;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_ALIGN   = 2'b01,
        ERR_BUS     = 2'b10,
        ERR_TIMEOUT = 2'b11
    } lsu_err_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MREQ = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // Signed and unsigned variants share the low two funct3 bits.
    function automatic logic [3:0] size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store shift/strobe generation, load extract and
// extension, and request legality check.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0]   addr,
    input  logic [2:0]        f3,
    input  logic              wen,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   beat,
    output logic              illegal,
    output logic [XLEN-1:0]   aligned_addr,
    output logic [XLEN-1:0]   lane_wdata,
    output logic [XLEN/8-1:0] wstrb,
    output logic [XLEN-1:0]   ld_data
);

    localparam int STRB = XLEN / 8;
    localparam int OFFW = $clog2(STRB);

    logic [OFFW-1:0] offset;
    logic [OFFW+2:0] bit_shift;
    logic [3:0]      nbytes;
    logic            misaligned;
    logic [STRB-1:0] strb_base;
    logic [XLEN-1:0] ext_mask;
    logic [XLEN-1:0] shifted;
    logic            sign_bit;

    assign offset       = addr[OFFW-1:0];
    assign bit_shift    = {offset, 3'b000};
    assign nbytes       = size_bytes(f3);
    assign aligned_addr = {addr[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign shifted      = beat >> bit_shift;
    assign lane_wdata   = wdata << bit_shift;

    always_comb begin
        misaligned = |(offset & OFFW'(nbytes - 4'd1));
        illegal    = (f3 == F3_ILL) || (wen && f3[2]) ||
                     ((XLEN == 32) && ((f3 == F3_D) || (f3 == F3_WU))) ||
                     misaligned;
    end

    always_comb begin
        strb_base = '1;
        ext_mask  = '1;
        sign_bit  = 1'b0;
        case (f3[1:0])
            2'b00: begin
                strb_base = STRB'(1);
                ext_mask  = XLEN'(8'hFF);
                sign_bit  = shifted[7];
            end
            2'b01: begin
                strb_base = STRB'(3);
                ext_mask  = XLEN'(16'hFFFF);
                sign_bit  = shifted[15];
            end
            2'b10: begin
                strb_base = STRB'(15);
                ext_mask  = XLEN'(32'hFFFF_FFFF);
                sign_bit  = shifted[31];
            end
            default: begin
                strb_base = '1;
                ext_mask  = '1;
                sign_bit  = 1'b0;
            end
        endcase
    end

    assign wstrb = wen ? (strb_base << offset) : '0;

    // f3[2] marks the unsigned variants; D has no bits left to extend.
    assign ld_data = (sign_bit && !f3[2]) ? (shifted | ~ext_mask)
                                          : (shifted & ext_mask);

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store front-end: one LSU request at a time, one aligned memory beat,
// with bus-error, timeout and late-response (stale) handling.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | req_ready high, waiting for a request
// MREQ    | presenting the memory beat (held off while stale is set)
// WAIT    | beat accepted, waiting for mem_rsp_valid or timeout
// RESP    | response presented until rsp_ready
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [2:0]        req_type,
    input  logic              req_wen,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_req_addr,
    output logic              mem_req_wen,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [XLEN/8-1:0] mem_req_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_rdata,
    input  logic              mem_rsp_err
);

    localparam int            CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

    logic [1:0]      state_q, state_d;
    logic            stale_q, stale_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [2:0]      type_q, type_d;
    logic            wen_q, wen_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    lsu_err_e        rsp_err_q, rsp_err_d;

    logic              in_idle, in_mreq;
    logic [XLEN-1:0]   al_addr, al_wdata;
    logic [2:0]        al_type;
    logic              al_wen, al_illegal;
    logic [XLEN-1:0]   al_aligned_addr, al_lane_wdata, al_ld_data;
    logic [XLEN/8-1:0] al_wstrb;

    assign in_idle = (state_q == ST_IDLE);
    assign in_mreq = (state_q == ST_MREQ);

    // In IDLE the aligner judges the incoming request; afterwards it works on the latched one.
    assign al_addr  = in_idle ? req_addr  : addr_q;
    assign al_type  = in_idle ? req_type  : type_q;
    assign al_wen   = in_idle ? req_wen   : wen_q;
    assign al_wdata = in_idle ? req_wdata : wdata_q;

    lsu_align #(.XLEN(XLEN)) u_align (
        .addr         (al_addr),
        .f3           (al_type),
        .wen          (al_wen),
        .wdata        (al_wdata),
        .beat         (mem_rsp_rdata),
        .illegal      (al_illegal),
        .aligned_addr (al_aligned_addr),
        .lane_wdata   (al_lane_wdata),
        .wstrb        (al_wstrb),
        .ld_data      (al_ld_data)
    );

    always_comb begin
        state_d     = state_q;
        stale_d     = stale_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        type_d      = type_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        if (stale_q && mem_rsp_valid) begin
            stale_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    type_d  = req_type;
                    wen_d   = req_wen;
                    wdata_d = req_wdata;
                    if (al_illegal) begin
                        state_d     = ST_RESP;
                        rsp_err_d   = ERR_ALIGN;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d = ST_MREQ;
                    end
                end
            end
            ST_MREQ: begin
                if (!stale_q && mem_req_ready) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                // A response in the timeout cycle wins over the timeout.
                if (mem_rsp_valid) begin
                    state_d = ST_RESP;
                    if (mem_rsp_err) begin
                        rsp_err_d   = ERR_BUS;
                        rsp_rdata_d = '0;
                    end else begin
                        rsp_err_d   = ERR_OK;
                        rsp_rdata_d = wen_q ? '0 : al_ld_data;
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == TC)) begin
                    state_d     = ST_RESP;
                    rsp_err_d   = ERR_TIMEOUT;
                    rsp_rdata_d = '0;
                    stale_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_rdata_d = '0;
                    rsp_err_d   = ERR_OK;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            stale_q     <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= '0;
            type_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= ERR_OK;
        end else begin
            state_q     <= state_d;
            stale_q     <= stale_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            type_q      <= type_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready     = in_idle;
    assign rsp_valid     = (state_q == ST_RESP);
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;
    assign mem_req_valid = in_mreq && !stale_q;
    assign mem_req_addr  = in_mreq ? al_aligned_addr : '0;
    assign mem_req_wen   = in_mreq && wen_q;
    assign mem_req_wdata = (in_mreq && wen_q) ? al_lane_wdata : '0;
    assign mem_req_wstrb = in_mreq ? al_wstrb : '0;

    // The memory may only answer an accepted beat or a beat already given up on.
    mem_rsp_unexpected: assert property (@(posedge clock) disable iff (reset)
        !(mem_rsp_valid && !stale_q && (state_q != ST_WAIT)));

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl (XLEN=64, TIMEOUT=8) with hand-computed
// expected values for loads, stores, illegal requests, timeout/stale and bus errors.
module tb_lsu_mem_ctrl;

    localparam int XLEN    = 64;
    localparam int TIMEOUT = 8;

    logic            clock;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic [2:0]      req_type;
    logic            req_wen;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic [1:0]      rsp_err;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_req_wen;
    logic [XLEN-1:0] mem_req_wdata;
    logic [7:0]      mem_req_wstrb;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_rdata;
    logic            mem_rsp_err;

    int errors  = 0;
    int checks  = 0;
    int cyc     = 0;
    int acc_cyc = 0;
    int mreq_cnt = 0;

    lsu_mem_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_type      (req_type),
        .req_wen       (req_wen),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wen   (mem_req_wen),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wstrb (mem_req_wstrb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .mem_rsp_err   (mem_rsp_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mem_req_valid) mreq_cnt <= mreq_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [63:0] a, input logic [2:0] t, input logic w,
                         input logic [63:0] d);
        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_addr  = a;
        req_type  = t;
        req_wen   = w;
        req_wdata = d;
        req_valid = 1'b1;
        acc_cyc   = cyc;
        step();
        req_valid = 1'b0;
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({tag, "_idle_after"}, {62'd0, req_ready, rsp_valid}, 64'd2);
    endtask

    task automatic txn(input string tag, input logic [63:0] a, input logic [2:0] t,
                       input logic w, input logic [63:0] d, input logic [63:0] beat,
                       input logic berr, input logic [63:0] exp_rdata,
                       input logic [1:0] exp_err, input logic [63:0] exp_maddr,
                       input logic [63:0] exp_mwdata, input logic [7:0] exp_wstrb);
        mem_req_ready = 1'b1;
        rsp_ready     = 1'b0;
        issue(a, t, w, d);
        chk({tag, "_mreq_valid"}, {63'd0, mem_req_valid}, 64'd1);
        chk({tag, "_mreq_addr"}, mem_req_addr, exp_maddr);
        chk({tag, "_mreq_wen"}, {63'd0, mem_req_wen}, {63'd0, w});
        chk({tag, "_mreq_wstrb"}, {56'd0, mem_req_wstrb}, {56'd0, exp_wstrb});
        if (w) chk({tag, "_mreq_wdata"}, mem_req_wdata, exp_mwdata);
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = beat;
        mem_rsp_err   = berr;
        step();
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        mem_rsp_rdata = '0;
        chk({tag, "_latency"}, 64'(cyc - acc_cyc), 64'd3);
        chk({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd1);
        chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, "_err"}, {62'd0, rsp_err}, {62'd0, exp_err});
        handshake(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        int m0;
        reset         = 1'b1;
        req_valid     = 1'b0;
        req_addr      = '0;
        req_type      = '0;
        req_wen       = 1'b0;
        req_wdata     = '0;
        rsp_ready     = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        mem_rsp_err   = 1'b0;
        step();
        step();
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_mreq_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_rsp_err", {62'd0, rsp_err}, 64'd0);
        chk("rst_mreq_wstrb", {56'd0, mem_req_wstrb}, 64'd0);
        reset = 1'b0;
        step();

        // Loads and stores through a zero-wait memory.
        txn("lw",  64'h8000_0004, 3'b010, 1'b0, 64'h0, 64'hDEAD_BEEF_8765_4321, 1'b0,
            64'hFFFF_FFFF_DEAD_BEEF, 2'b00, 64'h8000_0000, 64'h0, 8'h00);
        txn("sh",  64'h8000_0006, 3'b001, 1'b1, 64'h1234_ABCD, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
            64'h0, 2'b00, 64'h8000_0000, 64'hABCD_0000_0000_0000, 8'hC0);
        txn("lbu", 64'h8000_0003, 3'b100, 1'b0, 64'h0, 64'h0000_0000_8000_0000, 1'b0,
            64'h80, 2'b00, 64'h8000_0000, 64'h0, 8'h00);
        txn("lb",  64'h8000_0003, 3'b000, 1'b0, 64'h0, 64'h0000_0000_8000_0000, 1'b0,
            64'hFFFF_FFFF_FFFF_FF80, 2'b00, 64'h8000_0000, 64'h0, 8'h00);
        txn("lhu", 64'h8000_0002, 3'b101, 1'b0, 64'h0, 64'h0000_0000_8000_0000, 1'b0,
            64'h8000, 2'b00, 64'h8000_0000, 64'h0, 8'h00);
        txn("lh",  64'h8000_0006, 3'b001, 1'b0, 64'h0, 64'h8001_0000_0000_0000, 1'b0,
            64'hFFFF_FFFF_FFFF_8001, 2'b00, 64'h8000_0000, 64'h0, 8'h00);
        txn("lwu", 64'h8000_0004, 3'b110, 1'b0, 64'h0, 64'hDEAD_BEEF_8765_4321, 1'b0,
            64'h0000_0000_DEAD_BEEF, 2'b00, 64'h8000_0000, 64'h0, 8'h00);
        txn("lw0", 64'h8000_0000, 3'b010, 1'b0, 64'h0, 64'hFFFF_FFFF_1234_5678, 1'b0,
            64'h1234_5678, 2'b00, 64'h8000_0000, 64'h0, 8'h00);
        txn("ld",  64'h8000_0008, 3'b011, 1'b0, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0,
            64'h0123_4567_89AB_CDEF, 2'b00, 64'h8000_0008, 64'h0, 8'h00);
        txn("sb",  64'h8000_0007, 3'b000, 1'b1, 64'hAB, 64'h0, 1'b0,
            64'h0, 2'b00, 64'h8000_0000, 64'hAB00_0000_0000_0000, 8'h80);
        txn("sd",  64'h8000_0010, 3'b011, 1'b1, 64'h1122_3344_5566_7788, 64'h0, 1'b0,
            64'h0, 2'b00, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF);
        txn("sw",  64'h8000_0004, 3'b010, 1'b1, 64'hCAFE_F00D, 64'h0, 1'b0,
            64'h0, 2'b00, 64'h8000_0000, 64'hCAFE_F00D_0000_0000, 8'hF0);

        // Illegal requests answer at cycle 1 without touching memory.
        m0 = mreq_cnt;
        mem_req_ready = 1'b1;
        issue(64'h8000_0004, 3'b011, 1'b0, 64'h0);
        chk("ill_ld_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("ill_ld_err", {62'd0, rsp_err}, 64'd1);
        chk("ill_ld_rdata", rsp_rdata, 64'd0);
        handshake("ill_ld");
        issue(64'h8000_0000, 3'b111, 1'b0, 64'h0);
        chk("ill_t7_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("ill_t7_err", {62'd0, rsp_err}, 64'd1);
        handshake("ill_t7");
        issue(64'h8000_0000, 3'b100, 1'b1, 64'h55);
        chk("ill_sbu_err", {62'd0, rsp_err}, 64'd1);
        handshake("ill_sbu");
        chk("ill_no_mreq", 64'(mreq_cnt - m0), 64'd0);

        // Silent memory: timeout, then the next beat waits for the late response.
        mem_req_ready = 1'b1;
        issue(64'h10, 3'b010, 1'b0, 64'h0);
        chk("to_mreq_valid", {63'd0, mem_req_valid}, 64'd1);
        step();
        seen = -1;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) begin
                seen = cyc - acc_cyc;
                break;
            end
            step();
        end
        chk("to_latency", 64'(seen), 64'd10);
        chk("to_err", {62'd0, rsp_err}, 64'd3);
        chk("to_rdata", rsp_rdata, 64'd0);
        handshake("to");
        issue(64'h18, 3'b011, 1'b0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            chk("stale_hold", {63'd0, mem_req_valid}, 64'd0);
            if (i < 2) step();
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        step();
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        chk("stale_release", {63'd0, mem_req_valid}, 64'd1);
        chk("stale_addr", mem_req_addr, 64'h18);
        step();
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'h0123_4567_89AB_CDEF;
        step();
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        chk("post_to_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("post_to_rdata", rsp_rdata, 64'h0123_4567_89AB_CDEF);
        chk("post_to_err", {62'd0, rsp_err}, 64'd0);
        handshake("post_to");

        // Memory backpressure, bus error and a stalled response consumer.
        mem_req_ready = 1'b0;
        issue(64'h20, 3'b010, 1'b1, 64'hCAFE_F00D);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {63'd0, mem_req_valid}, 64'd1);
            chk("bp_addr", mem_req_addr, 64'h20);
            chk("bp_wen", {63'd0, mem_req_wen}, 64'd1);
            chk("bp_wdata", mem_req_wdata, 64'h0000_0000_CAFE_F00D);
            chk("bp_wstrb", {56'd0, mem_req_wstrb}, 64'h0F);
            step();
        end
        mem_req_ready = 1'b1;
        chk("bp_valid_last", {63'd0, mem_req_valid}, 64'd1);
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_err   = 1'b1;
        mem_rsp_rdata = 64'h5555_5555_5555_5555;
        step();
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        mem_rsp_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            chk("berr_valid", {63'd0, rsp_valid}, 64'd1);
            chk("berr_err", {62'd0, rsp_err}, 64'd2);
            chk("berr_rdata", rsp_rdata, 64'd0);
            step();
        end
        handshake("berr");
        txn("ld_berr", 64'h38, 3'b011, 1'b0, 64'h0, 64'h1111_2222_3333_4444, 1'b1,
            64'h0, 2'b10, 64'h38, 64'h0, 8'h00);

        // Reset in WAIT drops the transaction immediately.
        mem_req_ready = 1'b1;
        issue(64'h30, 3'b010, 1'b0, 64'h0);
        step();
        step();
        chk("rstw_pre_ready", {63'd0, req_ready}, 64'd0);
        reset = 1'b1;
        #1;
        chk("rstw_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rstw_mreq_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rstw_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        step();
        reset = 1'b0;
        step();
        txn("post_rst", 64'h8000_0004, 3'b010, 1'b0, 64'h0, 64'h7654_3210_0000_0000, 1'b0,
            64'h7654_3210, 2'b00, 64'h8000_0000, 64'h0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
